// File: rtl/vector_writeback_sequencer_if.sv
// Handshake and register-image bundle between an element producer and the
// vector writeback sequencer.
interface vector_writeback_sequencer_if #(
    parameter int VLEN = 128
);
    logic                 start;
    logic [4:0]           vd;
    logic [31:0]          vl;
    logic [31:0]          vstart;
    logic [2:0]           vsew;
    logic [2:0]           vlmul;
    logic                 vm;
    logic [VLEN-1:0]      masks;
    logic [VLEN*32-1:0]   cur_v_regs;
    logic                 elem_valid;
    logic [31:0]          elem_data;
    logic                 elem_ready;
    logic [VLEN*32-1:0]   new_v_regs;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output start, vd, vl, vstart, vsew, vlmul, vm, masks, cur_v_regs,
        output elem_valid, elem_data,
        input  elem_ready, new_v_regs, busy, done, error
    );

    modport slave (
        input  start, vd, vl, vstart, vsew, vlmul, vm, masks, cur_v_regs,
        input  elem_valid, elem_data,
        output elem_ready, new_v_regs, busy, done, error
    );
endinterface

// File: rtl/vector_writeback_sequencer.sv
// Merges a stream of element results into a shadow copy of the vector register
// file and presents the merged image for a single commit cycle.
module vector_writeback_sequencer #(
    parameter int VLEN = 128
) (
    input logic                          SYS_clk,
    input logic                          SYS_reset,
    vector_writeback_sequencer_if.slave  bus
);
    localparam int RF_W  = VLEN * 32;
    localparam int IDX_W = $clog2(VLEN);
    localparam int OFF_W = $clog2(RF_W);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        STREAM,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         idx_q, idx_d;
    logic                error_q, error_d;
    logic [RF_W-1:0]     shadow_q, shadow_d;
    logic                cap_en;

    logic [4:0]          vd_q;
    logic [31:0]         vl_q;
    logic [2:0]          vsew_q;
    logic [2:0]          vlmul_q;
    logic                vm_q;
    logic [VLEN-1:0]     masks_q;

    logic [4:0]          lmul_m1;
    logic [31:0]         vlmax;
    logic                cfg_err;
    logic [OFF_W-1:0]    wr_off;
    logic                wr_en;

    // VLMAX = VLEN*LMUL/SEW, with SEW = 8 << vsew
    always_comb begin
        lmul_m1 = (5'd1 << vlmul_q[1:0]) - 5'd1;
        vlmax   = (32'(VLEN) << vlmul_q[1:0]) >> ({1'b0, vsew_q[1:0]} + 3'd3);
        cfg_err = (vsew_q > 3'd2) || (vlmul_q > 3'd3) ||
                  ((vd_q & lmul_m1) != 5'd0) || (vl_q > vlmax);
    end

    // idx stays below VLMAX <= VLEN in STREAM, so the bit offset always fits
    assign wr_off = (OFF_W'(vd_q) * OFF_W'(VLEN)) +
                    (idx_q[OFF_W-1:0] << ({1'b0, vsew_q[1:0]} + 3'd3));
    assign wr_en  = vm_q || masks_q[idx_q[IDX_W-1:0]];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        error_d  = error_q;
        shadow_d = shadow_q;
        cap_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cap_en   = 1'b1;
                    shadow_d = bus.cur_v_regs;
                    idx_d    = bus.vstart;
                    error_d  = 1'b0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                error_d = cfg_err;
                if (cfg_err || (vl_q == 32'd0) || (idx_q >= vl_q)) begin
                    state_d = DONE;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.elem_valid) begin
                    if (wr_en) begin
                        case (vsew_q[1:0])
                            2'd0:    shadow_d[wr_off +: 8]  = bus.elem_data[7:0];
                            2'd1:    shadow_d[wr_off +: 16] = bus.elem_data[15:0];
                            default: shadow_d[wr_off +: 32] = bus.elem_data;
                        endcase
                    end
                    idx_d = idx_q + 32'd1;
                    if (idx_q == (vl_q - 32'd1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            error_q  <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            error_q  <= error_d;
            shadow_q <= shadow_d;
        end
    end

    // Configuration is only interpreted after CHECK, so it needs no reset
    always_ff @(posedge SYS_clk) begin
        if (cap_en) begin
            vd_q    <= bus.vd;
            vl_q    <= bus.vl;
            vsew_q  <= bus.vsew;
            vlmul_q <= bus.vlmul;
            vm_q    <= bus.vm;
            masks_q <= bus.masks;
        end
    end

    assign bus.elem_ready = (state_q == STREAM);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.error      = (state_q == DONE) && error_q;
    assign bus.new_v_regs = ((state_q == DONE) && !error_q) ? shadow_q : bus.cur_v_regs;
endmodule

// File: tb/tb_vector_writeback_sequencer.sv
// Directed bench for the vector writeback sequencer with a byte-level merge model.
module tb_vector_writeback_sequencer;
    localparam int VLEN = 128;
    localparam int RF_W = VLEN * 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_writeback_sequencer_if #(.VLEN(VLEN)) bus ();

    vector_writeback_sequencer #(.VLEN(VLEN)) dut (
        .SYS_clk   (clk),
        .SYS_reset (rst),
        .bus       (bus)
    );

    // Register file: latches new_v_regs every cycle unless the bench preloads it
    logic [RF_W-1:0] rf, load_img;
    logic            load_en;
    always @(posedge clk) rf <= load_en ? load_img : bus.new_v_regs;
    assign bus.cur_v_regs = rf;

    int tests = 0;
    int fails = 0;

    logic            chk_en  = 1'b0;
    logic            done_ok = 1'b0;
    logic            exp_err;
    logic [RF_W-1:0] exp_img;
    logic [31:0]     elems [0:127];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_img(input string name, input logic [RF_W-1:0] act, input logic [RF_W-1:0] exp);
        int w;
        tests++;
        if (act !== exp) begin
            fails++;
            w = 0;
            while (w < RF_W/32 - 1 && act[w*32 +: 32] === exp[w*32 +: 32]) w++;
            $display("FAIL %s: word %0d got %h expected %h", name, w, act[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    // Reference merge: element i of SEW bytes lands at byte vd*VLEN/8 + i*SEWbytes
    task automatic model(input logic [RF_W-1:0] base, input int vd, input int vl, input int vstart,
                         input int vsew, input int vlmul, input logic vm, input logic [VLEN-1:0] mk,
                         output logic [RF_W-1:0] img, output logic err, output int n);
        int sb, lm, vlmax;
        img = base;
        err = 1'b0;
        n   = 0;
        if (vsew > 2 || vlmul > 3) begin
            err = 1'b1;
        end else begin
            sb    = 1 << vsew;
            lm    = 1 << vlmul;
            vlmax = (VLEN / 8) * lm / sb;
            if ((vd % lm) != 0 || vl > vlmax) err = 1'b1;
        end
        if (!err && vstart < vl) begin
            n = vl - vstart;
            for (int i = vstart; i < vl; i++)
                if (vm || mk[i])
                    for (int b = 0; b < sb; b++)
                        img[(vd*(VLEN/8) + i*sb + b)*8 +: 8] = elems[i][b*8 +: 8];
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.done) begin
                chk("done_allowed", done_ok, 1);
                chk("error_at_done", bus.error, exp_err);
                chk("ready_in_done", bus.elem_ready, 0);
                chk_img("image_at_done", bus.new_v_regs, exp_img);
            end else begin
                chk_img("image_passthrough", bus.new_v_regs, rf);
            end
        end
    end

    task automatic preload(input logic [RF_W-1:0] img);
        load_img = img;
        load_en  = 1'b1;
        @(posedge clk); #1;
        load_en  = 1'b0;
    endtask

    task automatic set_cfg(input int vd, input int vl, input int vstart, input int vsew,
                           input int vlmul, input logic vm, input logic [VLEN-1:0] mk);
        bus.vd     = 5'(vd);
        bus.vl     = 32'(vl);
        bus.vstart = 32'(vstart);
        bus.vsew   = 3'(vsew);
        bus.vlmul  = 3'(vlmul);
        bus.vm     = vm;
        bus.masks  = mk;
    endtask

    task automatic run_op(input string tag, input int vd, input int vl, input int vstart, input int vsew,
                          input int vlmul, input logic vm, input logic [VLEN-1:0] mk, input int gap_mod);
        int n, k, first_rdy, last_hs, done_cyc;
        logic [RF_W-1:0] m_img;
        logic m_err;
        model(rf, vd, vl, vstart, vsew, vlmul, vm, mk, m_img, m_err, n);
        exp_img   = m_img;
        exp_err   = m_err;
        done_ok   = 1'b1;
        set_cfg(vd, vl, vstart, vsew, vlmul, vm, mk);
        bus.start = 1'b1;
        k = 0; first_rdy = -1; last_hs = -1; done_cyc = -1;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            bus.start      = 1'b0;
            bus.elem_valid = (k < n) && (gap_mod == 0 || (cyc % gap_mod) != 0);
            bus.elem_data  = (k < n) ? elems[vstart + k] : 32'hDEAD_BEEF;
            @(negedge clk);
            if (!bus.busy) chk({tag, "_busy"}, bus.busy, 1);
            if (bus.elem_ready && first_rdy < 0) first_rdy = cyc;
            if (bus.elem_ready && bus.elem_valid) begin
                k++;
                last_hs = cyc;
            end
            if (bus.done) done_cyc = cyc;
        end
        bus.elem_valid = 1'b0;
        chk({tag, "_done_seen"}, done_cyc > 0, 1);
        chk({tag, "_handshakes"}, k, n);
        if (n > 0) begin
            chk({tag, "_first_ready"}, first_rdy, 2);
            chk({tag, "_commit_lat"}, done_cyc, last_hs + 1);
        end else begin
            chk({tag, "_no_ready"}, first_rdy, -1);
            chk({tag, "_done_cycle"}, done_cyc, 2);
        end
        @(posedge clk); #1;
        done_ok = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_after"}, bus.busy, 0);
        chk_img({tag, "_committed"}, rf, m_img);
    endtask

    logic [RF_W-1:0] base, pre, tmp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        load_en = 1'b0;
        load_img = '0;
        bus.start = 1'b0;
        bus.elem_valid = 1'b0;
        bus.elem_data = '0;
        set_cfg(0, 0, 0, 0, 0, 1'b1, '0);
        for (int i = 0; i < 128; i++) elems[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_ready", bus.elem_ready, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_error", bus.error, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int p = 0; p < RF_W/8; p++) base[p*8 +: 8] = 8'(p * 7 + 3);
        preload(base);
        chk_en = 1'b1;

        // SEW=32, LMUL=1, vd=2, contiguous stream
        for (int i = 0; i < 4; i++) elems[i] = 32'h1111_1111 * (i + 1);
        run_op("sew32", 2, 4, 0, 2, 0, 1'b1, '0, 0);
        chk("sew32_v2", rf[2*VLEN +: VLEN], 128'h44444444_33333333_22222222_11111111);
        tmp = base;
        tmp[2*VLEN +: VLEN] = 128'h44444444_33333333_22222222_11111111;
        chk_img("sew32_others", rf, tmp);

        // SEW=8 masked with v1 preset to all ones, stalled producer
        tmp = rf;
        tmp[1*VLEN +: VLEN] = '1;
        preload(tmp);
        elems[0] = 32'hA0; elems[1] = 32'hA1; elems[2] = 32'hA2;
        run_op("mask8", 1, 3, 0, 0, 0, 1'b0, 128'b101, 2);
        chk("mask8_v1", rf[1*VLEN +: VLEN], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFA2FFA0);

        // LMUL=2 group spills into v5
        pre = rf;
        for (int i = 0; i < 6; i++) elems[i] = 32'(i);
        run_op("lmul2", 4, 6, 0, 2, 1, 1'b1, '0, 3);
        chk("lmul2_v4", rf[4*VLEN +: VLEN], 128'h00000003_00000002_00000001_00000000);
        chk("lmul2_v5_lo", rf[5*VLEN +: 64], 64'h00000005_00000004);
        chk("lmul2_v5_hi", rf[5*VLEN + 64 +: 64], pre[5*VLEN + 64 +: 64]);

        // Empty operations
        pre = rf;
        run_op("vl0", 0, 0, 0, 2, 0, 1'b1, '0, 0);
        run_op("vstart_eq_vl", 0, 5, 5, 2, 0, 1'b1, '0, 0);
        chk_img("empty_unchanged", rf, pre);

        // Illegal configurations
        run_op("vd_misalign", 3, 4, 0, 2, 1, 1'b1, '0, 0);
        run_op("sew_illegal", 0, 4, 0, 3, 0, 1'b1, '0, 0);
        run_op("lmul_illegal", 0, 4, 0, 0, 4, 1'b1, '0, 0);
        run_op("vl_gt_vlmax", 0, 5, 0, 2, 0, 1'b1, '0, 0);
        chk_img("error_unchanged", rf, pre);

        // SEW=16, LMUL=2 at VLMAX with vstart and a mask pattern
        for (int i = 0; i < 16; i++) elems[i] = 32'hBEEF_0000 | 32'(i * 32'h111);
        run_op("sew16_vlmax", 6, 16, 3, 1, 1, 1'b0, 128'hA5A5, 4);

        // SEW=8, LMUL=8 at VLMAX filling v8..v15
        for (int i = 0; i < 128; i++) elems[i] = 32'(i * 3 + 1);
        run_op("sew8_lmul8", 8, 128, 0, 0, 3, 1'b1, '0, 0);
        chk("sew8_v8_low", rf[8*VLEN +: 32], 32'h0A070401);

        // Reset after two of four handshakes
        pre = rf;
        for (int i = 0; i < 4; i++) elems[i] = 32'hC0DE_0000 + 32'(i);
        set_cfg(2, 4, 0, 2, 0, 1'b1, '0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.elem_valid = 1'b1;
        bus.elem_data  = elems[0];
        @(posedge clk); #1;
        bus.elem_data  = elems[1];
        @(posedge clk); #1;
        bus.elem_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_ready", bus.elem_ready, 0);
        repeat (4) @(negedge clk);
        chk_img("rst_mid_unchanged", rf, pre);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) elems[i] = 32'h0BAD_0000 + 32'(i);
        run_op("after_rst", 2, 4, 0, 2, 0, 1'b1, '0, 0);
        chk("after_rst_v2", rf[2*VLEN +: VLEN], 128'h0BAD0003_0BAD0002_0BAD0001_0BAD0000);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
